tx_bb_sample_feeder: RTL and testbench



---
 rtl/tx_bb_sample_feeder.sv | 152 +++++++++++++++
 tb/tb_tx_bb_sample_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_bb_sample_feeder.sv
// Baseband sample FIFO feeding the DUC glue. A burst FSM primes on threshold or EOB,
// gates the DUC enable and flags underrun and end-of-burst.
module tx_bb_sample_feeder #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [7:0]  SR_BASE    = 8'd0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  set_stb,
   input  logic [7:0]            set_addr,
   input  logic [31:0]           set_data,
   input  logic [31:0]           in_data,
   input  logic                  in_eob,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [31:0]           bb_sample,
   input  logic                  bb_strobe,
   output logic                  run,
   output logic                  underrun,
   output logic                  eob_ack,
   output logic [DEPTH_LOG2:0]   fill_level,
   output logic [31:0]           debug
);

   localparam int unsigned           DEPTH   = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [32:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   fill_cnt, eob_cnt, thresh, thresh_eff;
   logic                  push, pop, head_eob, push_eob, pop_eob;
   logic                  underrun_nxt, eob_ack_nxt;
   logic                  unused_set_bits;

   assign unused_set_bits = ^set_data[31:DEPTH_LOG2+1];

   // in_ready looks only at registered occupancy, so a same-cycle pop never raises it
   assign in_ready   = (fill_cnt != FULL);
   assign push       = in_valid && in_ready && !clear;
   assign head_eob   = mem[rd_ptr][32];
   assign push_eob   = push && in_eob;
   assign pop_eob    = pop && head_eob;
   assign fill_level = fill_cnt;
   assign thresh_eff = (thresh == '0 || thresh > FULL) ? FULL : thresh;

   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      underrun_nxt = 1'b0;
      eob_ack_nxt  = 1'b0;
      run          = 1'b0;
      bb_sample    = '0;
      case (state)
         ST_IDLE: begin
            if (fill_cnt >= thresh_eff || eob_cnt != '0)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            run = 1'b1;
            if (fill_cnt != '0)
               bb_sample = mem[rd_ptr][31:0];
            if (bb_strobe) begin
               if (fill_cnt != '0) begin
                  pop = 1'b1;
                  if (head_eob) begin
                     eob_ack_nxt = 1'b1;
                     state_nxt   = ST_IDLE;
                  end
               end else begin
                  underrun_nxt = 1'b1;
                  state_nxt    = ST_ERROR;
               end
            end
         end
         ST_ERROR: ;
         default: state_nxt = ST_IDLE;
      endcase
      if (clear) begin
         state_nxt    = ST_IDLE;
         pop          = 1'b0;
         underrun_nxt = 1'b0;
         eob_ack_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= {in_eob, in_data};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill_cnt <= '0;
         eob_cnt  <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill_cnt <= '0;
         eob_cnt  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fill_cnt <= fill_cnt + CNT_ONE;
            2'b01:   fill_cnt <= fill_cnt - CNT_ONE;
            default: fill_cnt <= fill_cnt;
         endcase
         case ({push_eob, pop_eob})
            2'b10:   eob_cnt <= eob_cnt + CNT_ONE;
            2'b01:   eob_cnt <= eob_cnt - CNT_ONE;
            default: eob_cnt <= eob_cnt;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         thresh <= CNT_ONE;
      else if (set_stb && set_addr == SR_BASE)
         thresh <= set_data[DEPTH_LOG2:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         underrun <= 1'b0;
         eob_ack  <= 1'b0;
      end else begin
         state    <= state_nxt;
         underrun <= underrun_nxt;
         eob_ack  <= eob_ack_nxt;
      end
   end

   assign debug = {2'(state), in_valid, in_ready, bb_strobe, run, underrun, eob_ack,
                   8'h00, 16'(fill_cnt)};

endmodule

// File: tb/tb_tx_bb_sample_feeder.sv
// Scenario bench for tx_bb_sample_feeder; accepted samples go to a scoreboard queue
// and are compared against bb_sample when the DUC strobe consumes them.
module tb_tx_bb_sample_feeder;

   logic        clock = 1'b0;
   logic        reset, clear, set_stb, in_eob, in_valid, bb_strobe;
   logic [7:0]  set_addr;
   logic [31:0] set_data, in_data;
   logic        in_ready, run, underrun, eob_ack;
   logic [31:0] bb_sample, debug;
   logic [4:0]  fill_level;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   tx_bb_sample_feeder #(.DEPTH_LOG2(4), .SR_BASE(8'd0)) dut (
      .clock(clock), .reset(reset), .clear(clear), .set_stb(set_stb),
      .set_addr(set_addr), .set_data(set_data), .in_data(in_data), .in_eob(in_eob),
      .in_valid(in_valid), .in_ready(in_ready), .bb_sample(bb_sample),
      .bb_strobe(bb_strobe), .run(run), .underrun(underrun), .eob_ack(eob_ack),
      .fill_level(fill_level), .debug(debug)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_thresh(input logic [31:0] v);
      set_stb = 1'b1; set_addr = 8'd0; set_data = v;
      tick();
      set_stb = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic e, input logic exp_acc);
      in_valid = 1'b1; in_data = d; in_eob = e;
      checks++;
      if (in_ready !== exp_acc) begin
         errors++;
         $display("FAIL push_in_ready: got %b expected %b (data %h)", in_ready, exp_acc, d);
      end
      if (exp_acc) exp_q.push_back({e, d});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic strobe(output logic eob_out);
      logic [32:0] head;
      bb_strobe = 1'b1;
      eob_out = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         if (bb_sample !== exp_q[0][31:0]) begin
            errors++;
            $display("FAIL bb_sample: got %h expected %h", bb_sample, exp_q[0][31:0]);
         end
      end
      tick();
      bb_strobe = 1'b0;
      if (exp_q.size() != 0) begin
         head = exp_q.pop_front();
         eob_out = head[32];
      end
   endtask

   task automatic do_clear(input logic with_push);
      clear = 1'b1;
      in_valid = with_push; in_data = 32'hDEAD_BEEF; in_eob = 1'b1;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", fill_level); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      checks++; if ({run, underrun, eob_ack} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {run, underrun, eob_ack}); end
      checks++; if (bb_sample !== 32'h0) begin errors++; $display("FAIL rst_bb_sample: got %h expected 0", bb_sample); end
      checks++; if (debug !== 32'h1000_0000) begin errors++; $display("FAIL rst_debug: got %h expected 10000000", debug); end
   endtask

   task automatic test_basic();
      logic e;
      push(32'h0001_0002, 1'b0, 1'b1);
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL basic_run_pre: got %b expected 0", run); end
      push(32'h0003_0004, 1'b1, 1'b1);
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL basic_run_up: got %b expected 1", run); end
      checks++; if (fill_level !== 5'd2) begin errors++; $display("FAIL basic_fill2: got %0d expected 2", fill_level); end
      strobe(e);
      checks++; if (eob_ack !== 1'b0) begin errors++; $display("FAIL basic_ack_early: got %b expected 0", eob_ack); end
      strobe(e);
      checks++; if (eob_ack !== 1'b1) begin errors++; $display("FAIL basic_eob_ack: got %b expected 1", eob_ack); end
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL basic_run_down: got %b expected 0", run); end
      checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL basic_fill0: got %0d expected 0", fill_level); end
      tick();
      checks++; if (eob_ack !== 1'b0) begin errors++; $display("FAIL basic_ack_once: got %b expected 0", eob_ack); end
   endtask

   task automatic test_thresh();
      logic e;
      set_thresh(32'd8);
      for (int i = 0; i < 7; i++) push(32'h8000_0000 + 32'(i), 1'b0, 1'b1);
      tick();
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL thr_run7: got %b expected 0", run); end
      checks++; if (fill_level !== 5'd7) begin errors++; $display("FAIL thr_fill7: got %0d expected 7", fill_level); end
      push(32'h8000_0007, 1'b0, 1'b1);
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL thr_run_same: got %b expected 0", run); end
      tick();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL thr_run8: got %b expected 1", run); end
      checks++; if (fill_level !== 5'd8) begin errors++; $display("FAIL thr_fill8: got %0d expected 8", fill_level); end
      for (int i = 0; i < 8; i++) strobe(e);
      checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL thr_drain: got %0d expected 0", fill_level); end
   endtask

   task automatic test_full();
      logic e;
      // still RUN with an empty FIFO: first push shows on bb_sample one cycle later
      push(32'hA000_0000, 1'b0, 1'b1);
      checks++; if (bb_sample !== 32'hA000_0000) begin errors++; $display("FAIL latency: got %h expected a0000000", bb_sample); end
      for (int i = 1; i < 16; i++) push(32'hA000_0000 + 32'(i), 1'b0, 1'b1);
      checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_fill: got %0d expected 16", fill_level); end
      push(32'hBAD0_0000, 1'b0, 1'b0);
      checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_overflow: got %0d expected 16", fill_level); end
      strobe(e);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", in_ready); end
      checks++; if (fill_level !== 5'd15) begin errors++; $display("FAIL full_fill15: got %0d expected 15", fill_level); end
      do_clear(1'b1);
      checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL clear_discard: got %0d expected 0", fill_level); end
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL clear_run: got %b expected 0", run); end
   endtask

   task automatic test_underrun();
      logic e;
      set_thresh(32'd2);
      push(32'hC000_0001, 1'b0, 1'b1);
      push(32'hC000_0002, 1'b0, 1'b1);
      tick();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL ur_run: got %b expected 1", run); end
      strobe(e);
      strobe(e);
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_early: got %b expected 0", underrun); end
      strobe(e);
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse: got %b expected 1", underrun); end
      checks++; if (run !== 1'b0 || bb_sample !== 32'h0) begin errors++; $display("FAIL ur_outputs: got run=%b bb=%h expected run=0 bb=0", run, bb_sample); end
      checks++; if (debug[31:30] !== 2'b10) begin errors++; $display("FAIL ur_state: got %b expected 10", debug[31:30]); end
      tick();
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_one_cycle: got %b expected 0", underrun); end
      push(32'hC000_0003, 1'b0, 1'b1);
      checks++; if (fill_level !== 5'd1 || run !== 1'b0 || bb_sample !== 32'h0) begin errors++; $display("FAIL ur_err_push: got fill=%0d run=%b bb=%h expected 1 0 0", fill_level, run, bb_sample); end
      do_clear(1'b0);
      checks++; if (fill_level !== 5'd0 || debug[31:30] !== 2'b00) begin errors++; $display("FAIL ur_clear: got fill=%0d st=%b expected 0 00", fill_level, debug[31:30]); end
   endtask

   task automatic test_eob_prime();
      logic e;
      set_thresh(32'd16);
      push(32'hE000_0001, 1'b0, 1'b1);
      push(32'hE000_0002, 1'b0, 1'b1);
      tick();
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL eobp_idle: got %b expected 0", run); end
      push(32'hE000_0003, 1'b1, 1'b1);
      tick();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL eobp_run: got %b expected 1", run); end
      for (int i = 0; i < 3; i++) strobe(e);
      checks++; if (eob_ack !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL eobp_ack: got ack=%b run=%b expected 1 0", eob_ack, run); end
   endtask

   task automatic test_back_to_back();
      logic e;
      push(32'hF000_0001, 1'b1, 1'b1);
      push(32'hF000_0002, 1'b0, 1'b1);
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL b2b_run1: got %b expected 1", run); end
      strobe(e);
      checks++; if (eob_ack !== 1'b1 || fill_level !== 5'd1) begin errors++; $display("FAIL b2b_ack1: got ack=%b fill=%0d expected 1 1", eob_ack, fill_level); end
      tick();
      checks++; if (run !== 1'b0 || fill_level !== 5'd1) begin errors++; $display("FAIL b2b_hold: got run=%b fill=%0d expected 0 1", run, fill_level); end
      push(32'hF000_0003, 1'b1, 1'b1);
      tick();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL b2b_run2: got %b expected 1", run); end
      strobe(e);
      strobe(e);
      checks++; if (eob_ack !== 1'b1 || fill_level !== 5'd0) begin errors++; $display("FAIL b2b_ack2: got ack=%b fill=%0d expected 1 0", eob_ack, fill_level); end
   endtask

   task automatic test_async_reset();
      logic e;
      set_thresh(32'd5);
      for (int i = 0; i < 5; i++) push(32'h5000_0000 + 32'(i), 1'b0, 1'b1);
      tick();
      checks++; if (run !== 1'b1 || fill_level !== 5'd5) begin errors++; $display("FAIL ar_pre: got run=%b fill=%0d expected 1 5", run, fill_level); end
      #2 reset = 1'b1;
      #1;
      checks++; if (run !== 1'b0 || fill_level !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_state: got run=%b fill=%0d rdy=%b expected 0 0 1", run, fill_level, in_ready); end
      checks++; if (bb_sample !== 32'h0 || underrun !== 1'b0 || eob_ack !== 1'b0) begin errors++; $display("FAIL ar_out: got bb=%h ur=%b ack=%b expected 0 0 0", bb_sample, underrun, eob_ack); end
      checks++; if (debug !== 32'h1000_0000) begin errors++; $display("FAIL ar_debug: got %h expected 10000000", debug); end
      #1 reset = 1'b0;
      exp_q.delete();
      tick();
      push(32'h6000_0001, 1'b0, 1'b1);
      tick();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL ar_thresh_reset: got %b expected 1", run); end
      strobe(e);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
      in_data = '0; in_eob = 1'b0; in_valid = 1'b0; bb_strobe = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_thresh();
      test_full();
      test_underrun();
      test_eob_prime();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
